// File: rtl/fsm_trace_checker.sv
// fsm_trace_checker
//   Passive monitor for the three sequence-FSM implementations (case,
//   memory and gate-level). On every posedge it samples the state codes
//   and the shared input `a`. It checks each step against the legal
//   transition graph and cross-compares the three codes. It keeps sticky
//   error flags, saturating counters and a snapshot of the first failure.
//
//   Optional build macro: FSMCHK_VISIT_EN. When it is defined, visit_cnt
//   carries five per-state visit counters. When it is undefined,
//   visit_cnt is tied to zero.
//
// Ports
//   clk           clock, all sampling on posedge
//   reset         asynchronous, active-low reset
//   a             FSM input bit (same bit the FSMs see)
//   code_case     reference state code (case FSM)
//   code_mem      memory-FSM state code
//   code_gate     gate-FSM state code
//   clear         synchronous clear of flags/counters; returns to SYNC
//   chk_state     INIT=0, SYNC=1, RUN=2, FAULT=3
//   err_illegal   sticky: code_case was not one of 0,2,3,4,5
//   err_trans     sticky: code_case did not follow the transition graph
//   err_mismatch  sticky: code_mem or code_gate differed from code_case
//   err_any       OR of the three sticky flags
//   err_count     saturating count of edges with at least one error
//   trans_count   saturating count of checked (RUN) edges
//   first_err     {prev_code, prev_a, code_case} at the first error
//   first_valid   first_err holds valid data
//   visit_cnt     5 x CNT_W visit counters; slot g at [g*CNT_W +: CNT_W]
//                 slot order: code0, code2, code3, code4, code5
module fsm_trace_checker #(
  parameter int CNT_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic [2:0]         code_case,
  input  logic [2:0]         code_mem,
  input  logic [2:0]         code_gate,
  input  logic               clear,
  output logic [1:0]         chk_state,
  output logic               err_illegal,
  output logic               err_trans,
  output logic               err_mismatch,
  output logic               err_any,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   trans_count,
  output logic [6:0]         first_err,
  output logic               first_valid,
  output logic [5*CNT_W-1:0] visit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_SYNC  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;

  logic [2:0]       r_prev_code;
  logic             r_prev_a;
  logic             r_err_illegal, r_err_trans, r_err_mismatch;
  logic [CNT_W-1:0] r_err_count, r_trans_count;
  logic [6:0]       r_first_err;
  logic             r_first_valid;

  logic             w_illegal, w_mismatch, w_prev_legal;
  logic [2:0]       w_exp_code;
  logic             w_trans_err, w_active, w_is_run, w_err;

  // Codes 1, 6 and 7 are never produced by a healthy FSM.
  assign w_illegal    = (code_case == 3'd1) || (code_case >= 3'd6);
  assign w_prev_legal = !((r_prev_code == 3'd1) || (r_prev_code >= 3'd6));
  assign w_mismatch   = (code_mem != code_case) || (code_gate != code_case);

  // Expected successor of the code captured on the previous edge.
  always_comb begin
    w_exp_code = 3'd0;
    case (r_prev_code)
      3'd0:    w_exp_code = r_prev_a ? 3'd4 : 3'd3;
      3'd2:    w_exp_code = 3'd4;
      3'd3:    w_exp_code = r_prev_a ? 3'd5 : 3'd2;
      3'd4:    w_exp_code = r_prev_a ? 3'd3 : 3'd0;
      3'd5:    w_exp_code = r_prev_a ? 3'd2 : 3'd0;
      default: w_exp_code = 3'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-edge check results
  always_comb begin
    w_state_nxt = r_state;
    w_trans_err = 1'b0;
    w_active    = 1'b1;
    w_is_run    = 1'b0;
    case (r_state)
      // First edge after reset: the FSMs must come out of reset at code 0.
      S_INIT: begin
        w_trans_err = (code_case != 3'd0);
        w_state_nxt = S_RUN;
      end
      // Capture-only edge; there is no trusted predecessor yet.
      S_SYNC: w_state_nxt = S_RUN;
      // A predecessor that was illegal has already been flagged, so its
      // successor is not judged.
      S_RUN: begin
        w_is_run    = 1'b1;
        w_trans_err = w_prev_legal && (code_case != w_exp_code);
        w_state_nxt = S_RUN;
      end
      S_FAULT: begin
        w_active    = 1'b0;
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_active    = 1'b0;
        w_state_nxt = S_SYNC;
      end
    endcase
    w_err = w_active && (w_illegal || w_mismatch || w_trans_err);
    if (w_err && (STOP_ON_ERR != 0)) w_state_nxt = S_FAULT;
    // clear wins over everything, including the checks of this edge.
    if (clear) w_state_nxt = S_SYNC;
  end

  // Capture registers, sticky flags, counters and first-failure snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_code    <= 3'd0;
      r_prev_a       <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_trans    <= 1'b0;
      r_err_mismatch <= 1'b0;
      r_err_count    <= '0;
      r_trans_count  <= '0;
      r_first_err    <= 7'd0;
      r_first_valid  <= 1'b0;
    end else if (clear) begin
      r_prev_code    <= code_case;
      r_prev_a       <= a;
      r_err_illegal  <= 1'b0;
      r_err_trans    <= 1'b0;
      r_err_mismatch <= 1'b0;
      r_err_count    <= '0;
      r_trans_count  <= '0;
      r_first_err    <= 7'd0;
      r_first_valid  <= 1'b0;
    end else if (w_active) begin
      r_prev_code <= code_case;
      r_prev_a    <= a;
      if (w_illegal)   r_err_illegal  <= 1'b1;
      if (w_trans_err) r_err_trans    <= 1'b1;
      if (w_mismatch)  r_err_mismatch <= 1'b1;
      if (w_is_run && (r_trans_count != CNT_MAX))
        r_trans_count <= r_trans_count + CNT_ONE;
      if (w_err) begin
        if (r_err_count != CNT_MAX) r_err_count <= r_err_count + CNT_ONE;
        if (!r_first_valid) begin
          r_first_err   <= {r_prev_code, r_prev_a, code_case};
          r_first_valid <= 1'b1;
        end
      end
    end
  end

  assign chk_state    = r_state;
  assign err_illegal  = r_err_illegal;
  assign err_trans    = r_err_trans;
  assign err_mismatch = r_err_mismatch;
  assign err_any      = r_err_illegal | r_err_trans | r_err_mismatch;
  assign err_count    = r_err_count;
  assign trans_count  = r_trans_count;
  assign first_err    = r_first_err;
  assign first_valid  = r_first_valid;

`ifdef FSMCHK_VISIT_EN
  logic [4:0] w_visit_hit;

  // One-hot slot select: code0, code2, code3, code4, code5.
  always_comb begin
    w_visit_hit = 5'b0;
    case (code_case)
      3'd0:    w_visit_hit = 5'b00001;
      3'd2:    w_visit_hit = 5'b00010;
      3'd3:    w_visit_hit = 5'b00100;
      3'd4:    w_visit_hit = 5'b01000;
      3'd5:    w_visit_hit = 5'b10000;
      default: w_visit_hit = 5'b00000;
    endcase
  end

  for (genvar g = 0; g < 5; g++) begin : g_visit
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_cnt <= '0;
      else if (clear)
        r_cnt <= '0;
      else if (w_active && w_visit_hit[g] && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CNT_ONE;
    end
    assign visit_cnt[g*CNT_W +: CNT_W] = r_cnt;
  end
`else
  assign visit_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_trace_checker.sv
module tb_fsm_trace_checker;

  logic       clk = 1'b0;
  logic       reset, a, clear;
  logic [2:0] code_case, code_mem, code_gate;

  // u0: CNT_W=8, keeps checking; u1: CNT_W=2, stops on first error.
  logic [1:0]  u0_st, u1_st;
  logic        u0_ei, u0_et, u0_em, u0_any, u0_fv;
  logic        u1_ei, u1_et, u1_em, u1_any, u1_fv;
  logic [7:0]  u0_ec, u0_tc;
  logic [1:0]  u1_ec, u1_tc;
  logic [6:0]  u0_fe, u1_fe;
  logic [39:0] u0_vis;
  logic [9:0]  u1_vis;

  fsm_trace_checker #(.CNT_W(8), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .reset(reset), .a(a), .code_case(code_case),
    .code_mem(code_mem), .code_gate(code_gate), .clear(clear),
    .chk_state(u0_st), .err_illegal(u0_ei), .err_trans(u0_et),
    .err_mismatch(u0_em), .err_any(u0_any), .err_count(u0_ec),
    .trans_count(u0_tc), .first_err(u0_fe), .first_valid(u0_fv),
    .visit_cnt(u0_vis));

  fsm_trace_checker #(.CNT_W(2), .STOP_ON_ERR(1)) u1 (
    .clk(clk), .reset(reset), .a(a), .code_case(code_case),
    .code_mem(code_mem), .code_gate(code_gate), .clear(clear),
    .chk_state(u1_st), .err_illegal(u1_ei), .err_trans(u1_et),
    .err_mismatch(u1_em), .err_any(u1_any), .err_count(u1_ec),
    .trans_count(u1_tc), .first_err(u1_fe), .first_valid(u1_fv),
    .visit_cnt(u1_vis));

  always #5 clk = ~clk;

  // Reference model state. st: 0 INIT, 1 SYNC, 2 RUN, 3 FAULT.
  typedef struct packed {
    int st, pc, pa, ei, et, em, ec, tc, fe, fv;
    logic [4:0][31:0] vc;
  } mdl_t;

  // Transition graph as lookup tables; -1 marks an illegal code.
  int nx0[8]     = '{3, -1, 4, 2, 0, 0, -1, -1};
  int nx1[8]     = '{4, -1, 4, 5, 3, 2, -1, -1};
  int slot_of[8] = '{0, -1, 1, 2, 3, 4, -1, -1};

  int n_pass = 0, n_total = 0;
  mdl_t m0, m1;
  mdl_t q0[$], q1[$];

  function automatic int nxt(int c, int ai);
    return (ai != 0) ? nx1[c] : nx0[c];
  endfunction

  function automatic mdl_t step(mdl_t m, bit rst_n, bit clr, int ai, int cc,
                                int cm, int cg, int mx, bit stop);
    mdl_t n;
    bit ill, mis, tr, e;
    n = '0;
    if (!rst_n) return n;
    if (clr) begin
      n.st = 1; n.pc = cc; n.pa = ai;
      return n;
    end
    n = m;
    if (m.st == 3) return n;
    ill = (nx0[cc] < 0);
    mis = (cm != cc) || (cg != cc);
    tr  = 1'b0;
    if (m.st == 0) tr = (cc != 0);
    else if (m.st == 2) begin
      if (nx0[m.pc] >= 0) tr = (cc != nxt(m.pc, m.pa));
      if (n.tc < mx) n.tc = n.tc + 1;
    end
    e = ill || tr || mis;
    if (ill) n.ei = 1;
    if (tr)  n.et = 1;
    if (mis) n.em = 1;
    if (e) begin
      if (n.ec < mx) n.ec = n.ec + 1;
      if (n.fv == 0) begin
        n.fe = m.pc * 16 + m.pa * 8 + cc;
        n.fv = 1;
      end
    end
    if (!ill && (n.vc[slot_of[cc]] < mx)) n.vc[slot_of[cc]] = n.vc[slot_of[cc]] + 1;
    n.st = (e && stop) ? 3 : 2;
    n.pc = cc;
    n.pa = ai;
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp(string tag, mdl_t e, int st, int ei, int et, int em,
                     int any, int ec, int tc, int fe, int fv,
                     logic [4:0][31:0] v);
    chk({tag, ".chk_state"}, st, e.st);
    chk({tag, ".err_illegal"}, ei, e.ei);
    chk({tag, ".err_trans"}, et, e.et);
    chk({tag, ".err_mismatch"}, em, e.em);
    chk({tag, ".err_any"}, any, ((e.ei | e.et | e.em) != 0) ? 1 : 0);
    chk({tag, ".err_count"}, ec, e.ec);
    chk({tag, ".trans_count"}, tc, e.tc);
    chk({tag, ".first_err"}, fe, e.fe);
    chk({tag, ".first_valid"}, fv, e.fv);
    for (int g = 0; g < 5; g++) begin
`ifdef FSMCHK_VISIT_EN
      chk($sformatf("%s.visit%0d", tag, g), int'(v[g]), int'(e.vc[g]));
`else
      chk($sformatf("%s.visit%0d", tag, g), int'(v[g]), 0);
`endif
    end
  endtask

  // Drive one cycle of stimulus, then advance the models on the edge
  // and queue what each DUT should show after it.
  task automatic cyc(bit rst_n, bit clr, bit ai, int cc, int cm, int cg);
    @(negedge clk);
    reset     = rst_n;
    clear     = clr;
    a         = ai;
    code_case = 3'(cc);
    code_mem  = 3'(cm);
    code_gate = 3'(cg);
    @(posedge clk);
    m0 = step(m0, rst_n, clr, ai, cc, cm, cg, 255, 1'b0);
    m1 = step(m1, rst_n, clr, ai, cc, cm, cg, 3, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  // Monitor: compares every DUT output against the queued expectation.
  initial begin
    mdl_t e;
    logic [4:0][31:0] v;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        for (int g = 0; g < 5; g++) v[g] = 32'(u0_vis[g*8 +: 8]);
        cmp("u0", e, int'(u0_st), int'(u0_ei), int'(u0_et), int'(u0_em),
            int'(u0_any), int'(u0_ec), int'(u0_tc), int'(u0_fe), int'(u0_fv), v);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        for (int g = 0; g < 5; g++) v[g] = 32'(u1_vis[g*2 +: 2]);
        cmp("u1", e, int'(u1_st), int'(u1_ei), int'(u1_et), int'(u1_em),
            int'(u1_any), int'(u1_ec), int'(u1_tc), int'(u1_fe), int'(u1_fv), v);
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    int g;
    bit ai, rn, cl;
    int cc, cm, cg;
    reset = 1'b0; clear = 1'b0; a = 1'b0;
    code_case = 3'd0; code_mem = 3'd0; code_gate = 3'd0;
    m0 = '0; m1 = '0;

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // a=0 walk: 0,3,2,4,0,3,2,4
    g = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, g, g, g);
      g = nxt(g, 0);
    end
    #3;
    chk("a0_walk.u0_trans_count", int'(u0_tc), 7);
    chk("a0_walk.u0_err_any", int'(u0_any), 0);
    chk("a0_walk.u0_first_valid", int'(u0_fv), 0);
    chk("a0_walk.u1_trans_count_sat", int'(u1_tc), 3);

    // a=1 walk: 0,4,3,5,2,4,3
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 1, g, g, g);
      g = nxt(g, 1);
    end
    #3;
    chk("a1_walk.u0_err_any", int'(u0_any), 0);
    chk("a1_walk.u0_trans_count", int'(u0_tc), 14);

    // 3 with a=1 must go to 5; present 4 instead.
    cyc(1, 0, 0, 4, 4, 4);
    g = nxt(4, 0);
    #3;
    chk("bad_trans.u0_err_trans", int'(u0_et), 1);
    chk("bad_trans.u0_err_count", int'(u0_ec), 1);
    chk("bad_trans.u0_first_err", int'(u0_fe), 7'h3C);
    chk("bad_trans.u1_fault", int'(u1_st), 3);
    for (int i = 0; i < 4; i++) begin
      ai = 1'($urandom_range(0, 1));
      cyc(1, 0, ai, g, g, g);
      g = nxt(g, int'(ai));
    end
    #3;
    chk("continue.u0_err_count", int'(u0_ec), 1);
    chk("continue.u0_state", int'(u0_st), 2);

    // clear, then a mismatch on the SYNC edge
    cyc(1, 1, 0, g, g, g);
    #3;
    chk("clear.u0_state", int'(u0_st), 1);
    chk("clear.u0_err_any", int'(u0_any), 0);
    chk("clear.u0_err_count", int'(u0_ec), 0);
    chk("clear.u1_state", int'(u1_st), 1);
    cyc(1, 0, 0, 2, 5, 2);
    g = 4;
    #3;
    chk("mismatch.u0_err_mismatch", int'(u0_em), 1);
    chk("mismatch.u0_err_count", int'(u0_ec), 1);
    chk("mismatch.u0_err_illegal", int'(u0_ei), 0);

    // illegal code 7 on all three taps; u1 stops
    cyc(1, 1, 0, g, g, g);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 4, 4, 4);
    cyc(1, 0, 0, 7, 7, 7);
    #3;
    chk("illegal.u1_err_illegal", int'(u1_ei), 1);
    chk("illegal.u1_err_count", int'(u1_ec), 1);
    chk("illegal.u1_state", int'(u1_st), 3);
    chk("illegal.u1_trans_count", int'(u1_tc), 2);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 3, 3, 3);
    #3;
    chk("frozen.u1_trans_count", int'(u1_tc), 2);
    chk("frozen.u1_state", int'(u1_st), 3);
    cyc(1, 1, 0, 2, 2, 2);
    #3;
    chk("unfault.u1_state", int'(u1_st), 1);
    chk("unfault.u1_err_any", int'(u1_any), 0);
    chk("unfault.u1_trans_count", int'(u1_tc), 0);
    chk("unfault.u1_first_valid", int'(u1_fv), 0);
    cyc(1, 0, 0, 4, 4, 4);
    #3;
    chk("unfault.u1_run", int'(u1_st), 2);
    g = nxt(4, 0);

    // randomized run: mostly legal walks with injected faults, clears, resets
    for (int i = 0; i < 2000; i++) begin
      rn = ($urandom_range(0, 249) != 0);
      cl = ($urandom_range(0, 79) == 0);
      ai = 1'($urandom_range(0, 1));
      cc = g;
      if ($urandom_range(0, 29) == 0) cc = int'($urandom_range(0, 7));
      cm = cc; cg = cc;
      if ($urandom_range(0, 29) == 0) cm = int'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) cg = int'($urandom_range(0, 7));
      cyc(rn, cl, ai, cc, cm, cg);
      g = (nx0[cc] >= 0) ? nxt(cc, int'(ai)) : 0;
      if (!rn) g = 0;
    end
    cyc(1, 0, 0, g, g, g);
    #4;
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
